// File: rtl/tuner_seq.sv
// tuner_seq: requests an FFT frame, finds the windowed peak bin, converts it to Hz and debounces the tuning verdict
module tuner_seq #(
    parameter int NUM_BINS    = 1024,
    parameter int BIN_LO      = 3,
    parameter int BIN_HI      = 511,
    parameter int MAG_W       = 32,
    parameter int SAMPLE_FREQ = 48000,
    parameter int SHIFT_BITS  = 10,
    parameter int STABLE_CNT  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [5:0]       expected,
    output logic             fft_start,
    input  logic             mag_valid,
    input  logic             mag_sop,
    input  logic             mag_eop,
    input  logic [MAG_W-1:0] mag,
    output logic [10:0]      peak_index,
    output logic [31:0]      freq,
    output logic [5:0]       note,
    output logic [1:0]       pitch,
    output logic             result_valid,
    output logic             frame_err,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_SOP, SCAN, CALC, CLASSIFY, PUBLISH} state_t;
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam logic [10:0] LO   = 11'(BIN_LO);
    localparam logic [10:0] HI   = 11'(BIN_HI);
    localparam logic [10:0] LAST = 11'(NUM_BINS - 1);
    localparam logic [SW-1:0] SAT = SW'(STABLE_CNT);

    state_t          r_state, w_next;
    logic [10:0]     r_bin, r_idx, w_bin_inc;
    logic [MAG_W-1:0] r_max, w_max0;
    logic [5:0]      r_exp, r_pexp, r_code, w_code;
    logic [31:0]     r_freq, w_lo, w_hi;
    logic [1:0]      r_v, r_pv, w_v;
    logic [SW-1:0]   r_stab, w_stab_n;
    logic            w_last, w_upd, w_ok, w_same;

    assign w_bin_inc = r_bin + 11'd1;
    assign w_last    = w_bin_inc == LAST;
    assign w_upd     = (w_bin_inc >= LO) && (w_bin_inc <= HI) && (mag > r_max);
    assign w_max0    = (BIN_LO == 0) ? mag : '0;
    assign w_same    = (r_stab != '0) && (r_v == r_pv) && (r_exp == r_pexp);
    assign w_stab_n  = !w_same ? SW'(1) : (r_stab == SAT) ? r_stab : r_stab + 1'b1;
    assign w_v       = !w_ok ? 2'b01 : (r_freq < w_lo) ? 2'b00 : (r_freq > w_hi) ? 2'b11 : 2'b10;

    // note thresholds for the latched string code; unknown codes are invalid
    always_comb begin
        w_lo   = '0;
        w_hi   = '0;
        w_ok   = 1'b1;
        w_code = r_exp;
        case (r_exp)
            6'd22:   begin w_lo = 32'd210; w_hi = 32'd230; end
            6'd25:   begin w_lo = 32'd240; w_hi = 32'd280; end
            6'd29:   begin w_lo = 32'd310; w_hi = 32'd360; end
            6'd32:   begin w_lo = 32'd380; w_hi = 32'd400; end
            default: begin w_ok = 1'b0; w_code = '0; end
        endcase
    end

    // next state and the one-cycle strobes
    always_comb begin
        w_next       = r_state;
        fft_start    = 1'b0;
        frame_err    = 1'b0;
        result_valid = 1'b0;
        busy         = r_state != IDLE;
        case (r_state)
            IDLE:     w_next = enable ? REQ : IDLE;
            REQ:      begin fft_start = 1'b1; w_next = WAIT_SOP; end
            WAIT_SOP: w_next = (mag_valid && mag_sop) ? SCAN : WAIT_SOP;
            SCAN: begin
                if (mag_valid) begin
                    if (mag_sop) frame_err = 1'b1;
                    else if (mag_eop && w_last) w_next = CALC;
                    else if (mag_eop || w_last) begin frame_err = 1'b1; w_next = REQ; end
                end
            end
            CALC:     w_next = CLASSIFY;
            CLASSIFY: w_next = PUBLISH;
            PUBLISH:  begin result_valid = 1'b1; w_next = enable ? REQ : IDLE; end
            default:  w_next = IDLE;
        endcase
    end

    // state register, peak scan, frequency/verdict pipeline and debounced outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_idx      <= '0;
            r_max      <= '0;
            r_exp      <= '0;
            r_pexp     <= '0;
            r_code     <= '0;
            r_freq     <= '0;
            r_v        <= 2'b01;
            r_pv       <= 2'b01;
            r_stab     <= '0;
            peak_index <= '0;
            freq       <= '0;
            note       <= '0;
            pitch      <= 2'b01;
        end else begin
            r_state <= w_next;
            case (r_state)
                WAIT_SOP: begin
                    if (mag_valid && mag_sop) begin
                        r_exp <= expected;
                        r_bin <= '0;
                        r_max <= w_max0;
                        r_idx <= '0;
                    end
                end
                SCAN: begin
                    if (mag_valid && mag_sop) begin
                        r_bin <= '0;
                        r_max <= w_max0;
                        r_idx <= '0;
                    end else if (mag_valid) begin
                        r_bin <= w_bin_inc;
                        if (w_upd) begin
                            r_max <= mag;
                            r_idx <= w_bin_inc;
                        end
                    end
                end
                CALC:     r_freq <= (32'(SAMPLE_FREQ) * {21'd0, r_idx}) >> SHIFT_BITS;
                CLASSIFY: begin r_v <= w_v; r_code <= w_code; end
                PUBLISH: begin
                    peak_index <= r_idx;
                    freq       <= r_freq;
                    r_stab     <= w_stab_n;
                    r_pv       <= r_v;
                    r_pexp     <= r_exp;
                    if (w_stab_n == SAT) begin
                        note  <= r_code;
                        pitch <= r_v;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tuner_seq.sv
// tb_tuner_seq: directed frame-level tests of the tuner sequencer
module tb_tuner_seq;
    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic [5:0]  expected = 6'd0;
    logic        mag_valid = 1'b0, mag_sop = 1'b0, mag_eop = 1'b0;
    logic [31:0] mag = 32'd0;
    logic        fft_start, result_valid, frame_err, busy;
    logic [10:0] peak_index;
    logic [31:0] freq;
    logic [5:0]  note;
    logic [1:0]  pitch;
    int checks = 0, errors = 0;
    int n_rv = 0, n_fe = 0;
    logic [31:0] fr [1024];

    tuner_seq dut (
        .clk(clk), .reset(reset), .enable(enable), .expected(expected),
        .fft_start(fft_start), .mag_valid(mag_valid), .mag_sop(mag_sop),
        .mag_eop(mag_eop), .mag(mag), .peak_index(peak_index), .freq(freq),
        .note(note), .pitch(pitch), .result_valid(result_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (result_valid) n_rv <= n_rv + 1;
        if (frame_err) n_fe <= n_fe + 1;
    end

    task fill(input logic [31:0] bg);
        for (int i = 0; i < 1024; i++) fr[i] = bg;
    endtask

    task send_frame(input int last, input bit stall);
        @(posedge clk); #1;
        for (int b = 0; b <= last; b++) begin
            if (stall && (b % 2 == 1)) begin
                mag_valid = 1'b0; mag_sop = 1'b0; mag_eop = 1'b0; mag = 32'hFFFF_FFFF;
                @(posedge clk); #1;
            end
            mag_valid = 1'b1; mag_sop = (b == 0); mag_eop = (b == last); mag = fr[b];
            @(posedge clk); #1;
        end
        mag_valid = 1'b0; mag_sop = 1'b0; mag_eop = 1'b0; mag = 32'd0;
    endtask

    task wait_result;
        int lat;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (result_valid) begin lat = i; break; end
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL latency: got %0d cycles, want 3", lat); end
        @(posedge clk); #1;
    endtask

    task wait_fs;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fft_start) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL fft_start: not seen within 20 cycles, want pulse"); end
    endtask

    task check_out(input string name, input logic [10:0] pi, input logic [31:0] f, input logic [5:0] n, input logic [1:0] p);
        checks++;
        if (peak_index !== pi || freq !== f || note !== n || pitch !== p) begin
            errors++;
            $display("FAIL %s: got idx=%0d freq=%0d note=%0d pitch=%b, want idx=%0d freq=%0d note=%0d pitch=%b",
                     name, peak_index, freq, note, pitch, pi, f, n, p);
        end
    endtask

    task test_reset;
        #12;
        checks++;
        if (busy !== 1'b0 || fft_start !== 1'b0 || result_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got busy=%b fs=%b rv=%b fe=%b, want 0", busy, fft_start, result_valid, frame_err);
        end
        check_out("reset_outs", 11'd0, 32'd0, 6'd0, 2'b01);
        #10 reset = 1'b1; enable = 1'b1; expected = 6'd22;
        wait_fs;
        checks++;
        if (busy !== 1'b1 || pitch !== 2'b01 || note !== 6'd0) begin
            errors++; $display("FAIL start_state: got busy=%b pitch=%b note=%0d, want 1 01 0", busy, pitch, note);
        end
        @(negedge clk);
        checks++;
        if (fft_start !== 1'b0) begin errors++; $display("FAIL fs_once: got %b, want 0", fft_start); end
    endtask

    task test_debounce;
        int rv0;
        rv0 = n_rv;
        fill(32'd2); fr[4] = 32'd100;
        for (int f = 0; f < 3; f++) begin
            send_frame(1023, 1'b0);
            wait_result;
            if (f < 2) check_out("debounce_early", 11'd4, 32'd187, 6'd0, 2'b01);
            else check_out("debounce_done", 11'd4, 32'd187, 6'd22, 2'b00);
            wait_fs;
        end
        checks++;
        if (n_rv - rv0 != 3) begin errors++; $display("FAIL rv_count: got %0d, want 3", n_rv - rv0); end
    endtask

    task test_no_debounce;
        #2 reset = 1'b0;
        #2 reset = 1'b1; expected = 6'd25;
        wait_fs;
        fill(32'd2); fr[5] = 32'd100;
        send_frame(1023, 1'b0);
        wait_result;
        check_out("nodeb_f1", 11'd5, 32'd234, 6'd0, 2'b01);
        wait_fs;
        fr[5] = 32'd2; fr[6] = 32'd100;
        for (int f = 0; f < 2; f++) begin
            send_frame(1023, 1'b0);
            wait_result;
            wait_fs;
        end
        check_out("nodeb_f3", 11'd6, 32'd281, 6'd0, 2'b01);
    endtask

    task test_tie;
        fill(32'd1); fr[10] = 32'd77; fr[20] = 32'd77;
        send_frame(1023, 1'b0);
        wait_result;
        check_out("tie", 11'd10, 32'd468, 6'd25, 2'b11);
        wait_fs;
    endtask

    task test_window_and_err;
        int rv0, fe0;
        fill(32'd3); fr[0] = 32'd2000; fr[1] = 32'd1000; fr[8] = 32'd500;
        send_frame(1023, 1'b0);
        wait_result;
        check_out("window", 11'd8, 32'd375, 6'd25, 2'b11);
        wait_fs;
        rv0 = n_rv; fe0 = n_fe;
        send_frame(500, 1'b0);
        wait_fs;
        checks++;
        if (n_fe - fe0 != 1 || n_rv != rv0) begin
            errors++; $display("FAIL early_eop: got fe=%0d rv=%0d, want fe=1 rv=0", n_fe - fe0, n_rv - rv0);
        end
    endtask

    task test_stall;
        fill(32'd3); fr[1] = 32'd1000; fr[8] = 32'd500;
        enable = 1'b0;
        send_frame(1023, 1'b1);
        wait_result;
        check_out("stall", 11'd8, 32'd375, 6'd25, 2'b11);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || fft_start !== 1'b0) begin
            errors++; $display("FAIL idle_after_disable: got busy=%b fs=%b, want 0 0", busy, fft_start);
        end
    endtask

    task test_async_reset;
        enable = 1'b1;
        wait_fs;
        @(posedge clk); #1;
        for (int b = 0; b < 100; b++) begin
            mag_valid = 1'b1; mag_sop = (b == 0); mag = 32'd9;
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fft_start !== 1'b0 || result_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL async_strobes: got busy=%b fs=%b rv=%b fe=%b, want 0", busy, fft_start, result_valid, frame_err);
        end
        check_out("async_outs", 11'd0, 32'd0, 6'd0, 2'b01);
        mag_valid = 1'b0; mag_sop = 1'b0; enable = 1'b0;
        #10 reset = 1'b1;
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_no_debounce;
        test_tie;
        test_window_and_err;
        test_stall;
        test_async_reset;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
